// File: rtl/divider_taint_track.sv
// Restoring unsigned divider with per-bit taint tracking.
// One quotient bit per cycle, MSB first; the result is published as a
// one-cycle strobe WIDTH+2 cycles after start is sampled, independent
// of operand values. Taint follows data through shift/subtract/select,
// and a control-taint flag marks whole operations started by a
// tainted start.
`timescale 1ns/1ps

module divider_taint_track #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] dividend_t,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] divisor_t,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] quotient_t,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] remainder_t,
    output logic             quotientDone,
    output logic             quotientDone_t
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;

    // Working datapath (no reset needed: always rewritten at LOAD)
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;

    // Taint state (reset so no stale taint leaks after reset)
    logic [WIDTH-1:0] r_dvd_t;
    logic [WIDTH-1:0] r_dvs_t;
    logic [WIDTH-1:0] r_rem_t;
    logic [WIDTH-1:0] r_quo_t;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_shift_t;
    logic [WIDTH:0]   w_opnd_t;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_diff_t;
    logic             w_borrow;
    logic             w_cmp_t;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_rem_t_nxt;
    logic [WIDTH-1:0] w_fill;
    logic             w_unused;

    // Bit i of the result is the OR of bits 0..i of the input: a borrow
    // can carry taint from any lower bit position upward.
    function automatic logic [WIDTH:0] prefix_or(input logic [WIDTH:0] v);
        logic [WIDTH:0] acc;
        logic           run;
        run = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            run    = run | v[i];
            acc[i] = run;
        end
        return acc;
    endfunction

    // Partial remainder is widened by one bit so the shift never loses
    // the MSB before the trial subtract.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_shift_t = {r_rem_t, r_dvd_t[WIDTH-1]};
    assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_opnd_t  = w_shift_t | {1'b0, r_dvs_t};
    assign w_diff_t  = prefix_or(w_opnd_t);
    // Top prefix bit is the OR of every operand taint bit.
    assign w_cmp_t   = w_diff_t[WIDTH];

    // When no borrow, the difference is below the divisor and fits WIDTH bits;
    // when borrowing, the shifted value is below the divisor as well.
    assign w_rem_nxt   = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_rem_t_nxt = w_cmp_t  ? {WIDTH{1'b1}}
                       : (w_borrow ? w_shift_t[WIDTH-1:0] : w_diff_t[WIDTH-1:0]);
    assign w_fill      = {WIDTH{r_flag}};
    assign w_unused    = w_diff[WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: w_next = ITER;
            ITER: if (r_cnt == LAST_ITER) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working datapath: latch operands, then one restoring step per cycle
    always_ff @(posedge clk) begin
        case (r_state)
            LOAD: begin
                r_dvd <= dividend;
                r_dvs <= divisor;
                r_rem <= '0;
                r_quo <= '0;
            end
            ITER: begin
                r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                r_rem <= w_rem_nxt;
                r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
            end
            default: ;
        endcase
    end

    // Control, taint tracking and published results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_flag         <= 1'b0;
            r_dvd_t        <= '0;
            r_dvs_t        <= '0;
            r_rem_t        <= '0;
            r_quo_t        <= '0;
            quotient       <= '0;
            quotient_t     <= '0;
            remainder      <= '0;
            remainder_t    <= '0;
            quotientDone   <= 1'b0;
            quotientDone_t <= 1'b0;
        end else begin
            quotientDone   <= 1'b0;
            quotientDone_t <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_cnt   <= '0;
                    r_flag  <= start_t;
                    r_dvd_t <= dividend_t | {WIDTH{start_t}};
                    r_dvs_t <= divisor_t  | {WIDTH{start_t}};
                    r_rem_t <= {WIDTH{start_t}};
                    r_quo_t <= {WIDTH{start_t}};
                end
                ITER: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_dvd_t <= {r_dvd_t[WIDTH-2:0], 1'b0} | w_fill;
                    r_rem_t <= w_rem_t_nxt | w_fill;
                    r_quo_t <= {r_quo_t[WIDTH-2:0], w_cmp_t} | w_fill;
                end
                DONE: begin
                    quotient       <= r_quo;
                    remainder      <= r_rem;
                    quotient_t     <= r_quo_t | w_fill;
                    remainder_t    <= r_rem_t | w_fill;
                    quotientDone   <= 1'b1;
                    quotientDone_t <= r_flag;
                    r_flag         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_taint_track.sv
`timescale 1ns/1ps

module tb_divider_taint_track;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         start_t;
    logic [W-1:0] dividend;
    logic [W-1:0] dividend_t;
    logic [W-1:0] divisor;
    logic [W-1:0] divisor_t;
    logic [W-1:0] quotient;
    logic [W-1:0] quotient_t;
    logic [W-1:0] remainder;
    logic [W-1:0] remainder_t;
    logic         quotientDone;
    logic         quotientDone_t;

    divider_taint_track #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_t        (start_t),
        .dividend       (dividend),
        .dividend_t     (dividend_t),
        .divisor        (divisor),
        .divisor_t      (divisor_t),
        .quotient       (quotient),
        .quotient_t     (quotient_t),
        .remainder      (remainder),
        .remainder_t    (remainder_t),
        .quotientDone   (quotientDone),
        .quotientDone_t (quotientDone_t)
    );

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] dvd_t;
        logic [W-1:0] dvs_t;
        logic         st_t;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] qt;
        logic [W-1:0] rt;
        logic         dt;
    } vec_t;

    typedef struct {
        vec_t        v;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_checks;
    int          n_errors;
    int          n_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding request
    always @(negedge clk) begin
        if (quotientDone === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", {31'b0, quotientDone}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient",       {24'b0, quotient},    {24'b0, e.v.q});
                chk("remainder",      {24'b0, remainder},   {24'b0, e.v.r});
                chk("quotient_t",     {24'b0, quotient_t},  {24'b0, e.v.qt});
                chk("remainder_t",    {24'b0, remainder_t}, {24'b0, e.v.rt});
                chk("quotientDone_t", {31'b0, quotientDone_t}, {31'b0, e.v.dt});
                chk("latency",        cyc - e.at, 32'd10);
            end
        end
    end

    task automatic drive(input vec_t v);
        dividend   = v.dvd;
        divisor    = v.dvs;
        dividend_t = v.dvd_t;
        divisor_t  = v.dvs_t;
        start_t    = v.st_t;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        e.v  = v;
        e.at = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"},  {24'b0, quotient},    32'd0);
        chk({tag, "_r"},  {24'b0, remainder},   32'd0);
        chk({tag, "_qt"}, {24'b0, quotient_t},  32'd0);
        chk({tag, "_rt"}, {24'b0, remainder_t}, 32'd0);
        chk({tag, "_dn"}, {30'b0, quotientDone, quotientDone_t}, 32'd0);
    endtask

    vec_t tbl[5];
    vec_t v;
    exp_t e;
    int   saved;

    initial begin
        //        dvd    dvs    dvd_t  dvs_t  st_t  q      r      qt     rt     dt
        tbl[0] = '{8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 8'd14, 8'd2,  8'h00, 8'h00, 1'b0};
        tbl[1] = '{8'd37,  8'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'd37, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{8'd100, 8'd7, 8'h00, 8'h01, 1'b0, 8'd14, 8'd2,  8'hFF, 8'hFF, 1'b0};
        tbl[3] = '{8'd100, 8'd7, 8'h01, 8'h00, 1'b0, 8'd14, 8'd2,  8'h01, 8'hFF, 1'b0};
        tbl[4] = '{8'd100, 8'd7, 8'h00, 8'h00, 1'b1, 8'd14, 8'd2,  8'hFF, 8'hFF, 1'b1};

        cyc = 0; n_checks = 0; n_errors = 0; n_done = 0;
        rst = 1'b0; start = 1'b0; start_t = 1'b0;
        dividend = '0; divisor = '0; dividend_t = '0; divisor_t = '0;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) apply(tbl[i]);

        // Abort mid-division with an asynchronous reset between clock edges
        @(negedge clk);
        v = tbl[0];
        drive(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        saved = n_done;
        repeat (15) @(negedge clk);
        chk("abort_no_done", n_done - saved, 32'd0);

        v = '{8'd200, 8'd9, 8'h00, 8'h00, 1'b0, 8'd22, 8'd2, 8'h00, 8'h00, 1'b0};
        apply(v);

        // start held high: two back-to-back operations, 11 edges apart
        @(negedge clk);
        v = tbl[0];
        drive(v);
        start = 1'b1;
        e.v = v; e.at = cyc + 1;  sb.push_back(e);
        e.v = v; e.at = cyc + 12; sb.push_back(e);
        saved = n_done;
        repeat (12) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        chk("b2b_count", n_done - saved, 32'd2);

        // Untainted random operands, reference from plain arithmetic
        for (int k = 0; k < 4; k++) begin
            v.dvd   = W'($urandom_range(0, 255));
            v.dvs   = W'($urandom_range(0, 15));
            v.dvd_t = '0;
            v.dvs_t = '0;
            v.st_t  = 1'b0;
            v.q     = (v.dvs == 0) ? 8'hFF : v.dvd / v.dvs;
            v.r     = (v.dvs == 0) ? v.dvd : v.dvd % v.dvs;
            v.qt    = '0;
            v.rt    = '0;
            v.dt    = 1'b0;
            apply(v);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
